// File: rtl/tia_horizontal_decode.sv
// Horizontal line-timing decoder: samples the 6-bit horizontal LFSR on hphi2 strobes
// and drives the HSYNC/HBLANK/burst/centre latches, the WSYNC RDY handshake and HMOVE extension.
module tia_horizontal_decode #(
  parameter logic [5:0] SHB_VAL  = 6'b010100,
  parameter logic [5:0] SHS_VAL  = 6'b111100,
  parameter logic [5:0] RHS_VAL  = 6'b110111,
  parameter logic [5:0] RCB_VAL  = 6'b001111,
  parameter logic [5:0] RHB_VAL  = 6'b011100,
  parameter logic [5:0] LRHB_VAL = 6'b010111,
  parameter logic [5:0] CNT_VAL  = 6'b101100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hphi2,
  input  logic [5:0] lfsr,
  input  logic       wsync_req,
  input  logic       hmove_req,
  output logic       hsync,
  output logic       hblank,
  output logic       cburst,
  output logic       center,
  output logic       shb,
  output logic       rdy,
  output logic       hmove_active
);

  // Handshake: wsync_req and hmove_req are single-clk strobes with no ready of their own;
  // they are accepted on the clk they are high. rdy is the CPU's ready, low while WSYNC waits.

  function automatic bit params_distinct();
    logic [5:0] v [7];
    bit ok;
    v[0] = SHB_VAL; v[1] = SHS_VAL; v[2] = RHS_VAL; v[3] = RCB_VAL;
    v[4] = RHB_VAL; v[5] = LRHB_VAL; v[6] = CNT_VAL;
    ok = 1'b1;
    for (int i = 0; i < 7; i++)
      for (int j = i + 1; j < 7; j++)
        if (v[i] == v[j]) ok = 1'b0;
    return ok;
  endfunction

  localparam bit PARAMS_OK = params_distinct();

  generate
    if (!PARAMS_OK) begin : g_param_check
      $error("tia_horizontal_decode: decode values must be distinct");
    end
  endgenerate

  // Every line-timing latch is a two-state set/reset machine.
  typedef enum logic {
    LAT_CLR = 1'b0,
    LAT_SET = 1'b1
  } latch_t;

  typedef struct packed {
    logic shb;
    logic shs;
    logic rhs;
    logic rcb;
    logic rhb;
    logic lrhb;
    logic cnt;
  } dec_t;

  dec_t   dec;
  latch_t hsync_q,  hsync_d;
  latch_t hblank_q, hblank_d;
  latch_t cburst_q, cburst_d;
  latch_t center_q, center_d;
  latch_t rdy_q,    rdy_d;
  latch_t hmove_q,  hmove_d;
  logic   shb_q,    shb_d;

  // Decode is qualified by hphi2 so the LFSR is only looked at while it is stable.
  always_comb begin
    dec = '0;
    if (hphi2) begin
      dec.shb  = (lfsr == SHB_VAL);
      dec.shs  = (lfsr == SHS_VAL);
      dec.rhs  = (lfsr == RHS_VAL);
      dec.rcb  = (lfsr == RCB_VAL);
      dec.rhb  = (lfsr == RHB_VAL);
      dec.lrhb = (lfsr == LRHB_VAL);
      dec.cnt  = (lfsr == CNT_VAL);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_q  <= LAT_CLR;
      hblank_q <= LAT_SET;
      cburst_q <= LAT_CLR;
      center_q <= LAT_CLR;
      rdy_q    <= LAT_SET;
      hmove_q  <= LAT_CLR;
      shb_q    <= 1'b0;
    end else begin
      hsync_q  <= hsync_d;
      hblank_q <= hblank_d;
      cburst_q <= cburst_d;
      center_q <= center_d;
      rdy_q    <= rdy_d;
      hmove_q  <= hmove_d;
      shb_q    <= shb_d;
    end
  end

  always_comb begin
    hsync_d  = hsync_q;
    hblank_d = hblank_q;
    cburst_d = cburst_q;
    center_d = center_q;
    rdy_d    = rdy_q;
    hmove_d  = hmove_q;
    shb_d    = dec.shb;

    if (dec.shs) begin
      hsync_d  = LAT_SET;
      cburst_d = LAT_SET;
    end
    if (dec.rhs) hsync_d = LAT_CLR;
    if (dec.rcb) cburst_d = LAT_CLR;

    if (dec.shb) begin
      hblank_d = LAT_SET;
      center_d = LAT_CLR;
    end
    // The normal end of blank is skipped while an HMOVE is pending; the late one always ends it.
    if (dec.rhb && (hmove_q == LAT_CLR)) hblank_d = LAT_CLR;
    if (dec.lrhb) hblank_d = LAT_CLR;
    if (dec.cnt) center_d = LAT_SET;

    // A request coinciding with the end-of-line decode beats the release/clear.
    if (wsync_req)    rdy_d = LAT_CLR;
    else if (dec.shb) rdy_d = LAT_SET;

    if (hmove_req)    hmove_d = LAT_SET;
    else if (dec.shb) hmove_d = LAT_CLR;
  end

  assign hsync        = (hsync_q  == LAT_SET);
  assign hblank       = (hblank_q == LAT_SET);
  assign cburst       = (cburst_q == LAT_SET);
  assign center       = (center_q == LAT_SET);
  assign rdy          = (rdy_q    == LAT_SET);
  assign hmove_active = (hmove_q  == LAT_SET);
  assign shb          = shb_q;

endmodule

// File: tb/tb_tia_horizontal_decode.sv
// Bench for tia_horizontal_decode: drives lines of LFSR strobes (with random filler states and
// random strobe spacing) and compares every clk against an event-table model of line timing.
module tb_tia_horizontal_decode;

  localparam logic [5:0] SHB_VAL  = 6'b010100;
  localparam logic [5:0] SHS_VAL  = 6'b111100;
  localparam logic [5:0] RHS_VAL  = 6'b110111;
  localparam logic [5:0] RCB_VAL  = 6'b001111;
  localparam logic [5:0] RHB_VAL  = 6'b011100;
  localparam logic [5:0] LRHB_VAL = 6'b010111;
  localparam logic [5:0] CNT_VAL  = 6'b101100;

  logic       clk;
  logic       reset;
  logic       hphi2;
  logic [5:0] lfsr;
  logic       wsync_req;
  logic       hmove_req;
  logic       hsync, hblank, cburst, center, shb, rdy, hmove_active;

  tia_horizontal_decode dut (
    .clk          (clk),
    .reset        (reset),
    .hphi2        (hphi2),
    .lfsr         (lfsr),
    .wsync_req    (wsync_req),
    .hmove_req    (hmove_req),
    .hsync        (hsync),
    .hblank       (hblank),
    .cburst       (cburst),
    .center       (center),
    .shb          (shb),
    .rdy          (rdy),
    .hmove_active (hmove_active)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [6:0] exp_q[$];

  // Model state, named by line-timing meaning.
  bit m_hsync, m_hblank, m_cburst, m_center, m_shb, m_rdy, m_hmove;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [6:0] model_vec();
    return {m_hsync, m_hblank, m_cburst, m_center, m_shb, m_rdy, m_hmove};
  endfunction

  task automatic model_reset();
    m_hsync = 0; m_hblank = 1; m_cburst = 0; m_center = 0;
    m_shb = 0; m_rdy = 1; m_hmove = 0;
  endtask

  // Count in the line at which each named LFSR value occurs.
  function automatic int count_of(input logic [5:0] v);
    case (v)
      SHB_VAL:  return 56;
      SHS_VAL:  return 4;
      RHS_VAL:  return 8;
      RCB_VAL:  return 12;
      RHB_VAL:  return 16;
      LRHB_VAL: return 18;
      CNT_VAL:  return 36;
      default:  return -1;
    endcase
  endfunction

  // One clk of the line-timing rules, driven by which line event (if any) was strobed.
  task automatic model_step(input bit hp, input logic [5:0] lv, input bit ws, input bit hm);
    int ev;
    bit was_hmove;
    ev = hp ? count_of(lv) : -1;
    was_hmove = m_hmove;
    m_shb = (ev == 56);
    case (ev)
      4:  begin m_hsync = 1; m_cburst = 1; end
      8:  m_hsync = 0;
      12: m_cburst = 0;
      16: if (!was_hmove) m_hblank = 0;
      18: m_hblank = 0;
      36: m_center = 1;
      56: begin m_hblank = 1; m_center = 0; end
      default: ;
    endcase
    if (ws) m_rdy = 0;
    else if (ev == 56) m_rdy = 1;
    if (hm) m_hmove = 1;
    else if (ev == 56) m_hmove = 0;
  endtask

  task automatic compare_outputs(input logic [6:0] e);
    check("hsync",        hsync,        e[6]);
    check("hblank",       hblank,       e[5]);
    check("cburst",       cburst,       e[4]);
    check("center",       center,       e[3]);
    check("shb",          shb,          e[2]);
    check("rdy",          rdy,          e[1]);
    check("hmove_active", hmove_active, e[0]);
  endtask

  // ---------------- driver ----------------
  // Entered just after a negedge; leaves just after the next negedge with outputs checked.
  task automatic tick(input bit hp, input logic [5:0] lv, input bit ws, input bit hm);
    hphi2 = hp; lfsr = lv; wsync_req = ws; hmove_req = hm;
    @(posedge clk);
    model_step(hp, lv, ws, hm);
    exp_q.push_back(model_vec());
    @(negedge clk);
    hphi2 = 1'b0; wsync_req = 1'b0; hmove_req = 1'b0;
    lfsr = 6'($urandom_range(0, 63));
    if (exp_q.size() == 0) check("sb_empty", 1'b1, 1'b0);
    else compare_outputs(exp_q.pop_front());
  endtask

  function automatic logic [5:0] filler();
    logic [5:0] v;
    do v = 6'($urandom_range(0, 63)); while (count_of(v) != -1);
    return v;
  endfunction

  function automatic logic [5:0] val_at(input int c);
    case (c)
      4:  return SHS_VAL;
      8:  return RHS_VAL;
      12: return RCB_VAL;
      16: return RHB_VAL;
      18: return LRHB_VAL;
      36: return CNT_VAL;
      56: return SHB_VAL;
      default: return filler();
    endcase
  endfunction

  // Walk counts c0..c1; gap<0 picks a random gap per strobe. rnd adds random request pulses.
  task automatic run_counts(input int c0, input int c1, input int gap, input int hm_at,
                            input int ws_at, input bit ws_on_shb, input bit rnd);
    int g;
    for (int c = c0; c <= c1; c++) begin
      g = (gap < 0) ? int'($urandom_range(0, 4)) : gap;
      for (int k = 0; k < g; k++)
        tick(1'b0, filler(), rnd && ($urandom_range(0, 15) == 0),
             rnd && ($urandom_range(0, 15) == 0));
      tick(1'b1, val_at(c), (c == ws_at) || (ws_on_shb && c == 56), c == hm_at);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    hphi2 = 0; lfsr = 6'd0; wsync_req = 0; hmove_req = 0;
    reset = 1'b1;
    model_reset();
    #1;
    compare_outputs(model_vec());
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Plain line, strobe every 4 clk.
    run_counts(0, 56, 3, -1, -1, 0, 0);
    // HMOVE early in the line, then a normal line after it.
    run_counts(0, 56, 3, 2, -1, 0, 0);
    run_counts(0, 56, 3, -1, -1, 0, 0);
    // WSYNC mid-line.
    run_counts(0, 56, 3, -1, 30, 0, 0);
    // WSYNC together with the end-of-line decode, then the whole next line held.
    run_counts(0, 56, 3, -1, -1, 1, 0);
    run_counts(0, 56, 3, -1, -1, 0, 0);
    // HMOVE after the normal blank end: no extension on the next line.
    run_counts(0, 56, 2, 20, -1, 0, 0);
    run_counts(0, 56, 2, -1, -1, 0, 0);

    // Illegal LFSR state strobed repeatedly.
    run_counts(0, 20, 3, -1, -1, 0, 0);
    for (int i = 0; i < 12; i++) tick(1'b1, 6'b000001, 1'b0, 1'b0);
    run_counts(21, 56, 3, -1, -1, 0, 0);

    // Reset mid-line with hsync high; checked before any clk edge.
    run_counts(0, 6, 3, 1, 3, 0, 0);
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    compare_outputs(model_vec());
    @(negedge clk);
    reset = 1'b0;
    run_counts(7, 56, 3, -1, -1, 0, 0);

    // Randomised lines with random spacing and request pulses.
    for (int l = 0; l < 4; l++)
      run_counts(0, 56, -1, int'($urandom_range(0, 60)), int'($urandom_range(0, 60)),
                 1'($urandom_range(0, 1)), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
